button_event_classifier: RTL and testbench

- Downstream consumer of the Debouncer stage; takes the clean debounced level (Debouncer_out) and converts it into single-cycle event pulses: press, release, short press, long press, double click.
- Sits between the Debouncer and the control/UI logic, so consumers never do their own edge detection or hold timing.
- Purely synchronous to CLK; no synchronizer inside, because the input is already synchronized and debounced.

---
 rtl/btn_pkg.sv | 13 +
 rtl/edge_detect.sv | 27 ++
 rtl/button_event_classifier.sv | 118 +++++++++++
 tb/tb_button_event_classifier.sv | 108 ++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state encoding and default timing for the button event blocks
package btn_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_2ND  = 3'd3,
    PRESSED_2 = 3'd4
  } btn_state_t;
  localparam int LONG_CYCLES_DEF = 100;
  localparam int GAP_CYCLES_DEF  = 40;
  localparam int PULSE_WIDTH     = 1;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: rise/fall strobes on a synchronous level, masked for the first cycle after reset
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic prev_q, prev_d, init_q, init_d;
  // history tracks the input every cycle; init only survives the first cycle out of reset
  always_comb begin
    prev_d = din;
    init_d = 1'b0;
  end
  // history registers; init_q=1 hides a level that was already high at reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      init_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
      init_q <= init_d;
    end
  end
  assign rise = ~init_q & din & ~prev_q;
  assign fall = ~init_q & ~din & prev_q;
endmodule

// File: rtl/button_event_classifier.sv
// button_event_classifier: turns a debounced button level into press/release/short/long/double-click pulses
module button_event_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int CNT_WIDTH   = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic debounced_IN,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic dclick_pulse,
  output logic busy
);
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
  btn_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic press_q, press_d, rel_q, rel_d, short_q, short_d;
  logic long_q, long_d, dclick_q, dclick_d, busy_q, busy_d;
  logic rise, fall;
  edge_detect u_edge (
    .clk  (CLK),
    .rst_n(RST),
    .din  (debounced_IN),
    .rise (rise),
    .fall (fall)
  );
  // classifier FSM: fall beats long timeout in PRESSED, rise beats gap timeout in WAIT_2ND
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    dclick_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_2ND;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          rel_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_2ND: begin
        cnt_d = cnt_q + 1'b1;
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = PRESSED_2;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESSED_2: begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        if (fall) begin
          rel_d    = 1'b1;
          dclick_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state, counter and registered pulse outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      dclick_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      short_q  <= short_d;
      long_q   <= long_d;
      dclick_q <= dclick_d;
      busy_q   <= busy_d;
    end
  end
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign dclick_pulse  = dclick_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_button_event_classifier.sv
// tb_button_event_classifier: directed cycle-by-cycle checks of all pulse outputs and busy
module tb_button_event_classifier;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic press_pulse, release_pulse, short_pulse, long_pulse, dclick_pulse, busy;
  int errors = 0;
  int checks = 0;
  // {busy, dclick, long, short, release, press}
  localparam logic [5:0] O  = 6'b000000;
  localparam logic [5:0] B  = 6'b100000;
  localparam logic [5:0] P  = 6'b100001;
  localparam logic [5:0] R  = 6'b100010;
  localparam logic [5:0] S  = 6'b000100;
  localparam logic [5:0] L  = 6'b101000;
  localparam logic [5:0] RI = 6'b000010;
  localparam logic [5:0] D  = 6'b010010;
  button_event_classifier #(.LONG_CYCLES(8), .GAP_CYCLES(6), .CNT_WIDTH(8)) dut (
    .CLK          (clk),
    .RST          (rst),
    .debounced_IN (din),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .dclick_pulse (dclick_pulse),
    .busy         (busy)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] obs();
    return {busy, dclick_pulse, long_pulse, short_pulse, release_pulse, press_pulse};
  endfunction
  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = obs();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed {busy,dclick,long,short,rel,press}=%b expected=%b", tag, $time, got, exp);
    end
  endtask
  // apply a level for one clock, then check the outputs registered on that edge
  task automatic cyc(input logic v, input logic [5:0] exp, input string tag);
    din = v;
    @(negedge clk);
    check(tag, exp);
  endtask
  initial begin
    din = 1'b1;
    repeat (2) @(negedge clk);
    check("in_reset", O);
    rst = 1'b1;
    cyc(1, O, "hi_at_release_a");
    cyc(1, O, "hi_at_release_b");
    cyc(0, O, "fall_idle_a");
    cyc(0, O, "fall_idle_b");
    cyc(1, P, "short_press");
    cyc(1, B, "short_hold1");
    cyc(1, B, "short_hold2");
    cyc(0, R, "short_release");
    for (int i = 0; i < 5; i++) cyc(0, B, "short_gap");
    cyc(0, S, "short_pulse");
    for (int i = 0; i < 4; i++) cyc(0, O, "short_after");
    cyc(1, P, "long_press");
    for (int i = 0; i < 7; i++) cyc(1, B, "long_hold");
    cyc(1, L, "long_pulse");
    for (int i = 0; i < 11; i++) cyc(1, B, "long_held");
    cyc(0, RI, "long_release");
    for (int i = 0; i < 8; i++) cyc(0, O, "long_after");
    cyc(1, P, "dc_press1");
    cyc(1, B, "dc_hold1");
    cyc(0, R, "dc_release1");
    cyc(0, B, "dc_gap1");
    cyc(0, B, "dc_gap2");
    cyc(1, P, "dc_press2");
    cyc(1, B, "dc_hold2");
    cyc(0, D, "dc_dclick");
    for (int i = 0; i < 8; i++) cyc(0, O, "dc_after");
    cyc(1, P, "gap_press1");
    cyc(0, R, "gap_release1");
    for (int i = 0; i < 5; i++) cyc(0, B, "gap_wait");
    cyc(1, P, "gap_tie_press2");
    cyc(0, D, "gap_tie_dclick");
    for (int i = 0; i < 7; i++) cyc(0, O, "gap_tie_after");
    cyc(1, P, "late_press1");
    cyc(0, R, "late_release1");
    for (int i = 0; i < 5; i++) cyc(0, B, "late_wait");
    cyc(0, S, "late_short");
    cyc(1, P, "late_new_press");
    cyc(0, R, "late_new_release");
    for (int i = 0; i < 5; i++) cyc(0, B, "late_new_wait");
    cyc(0, S, "late_new_short");
    cyc(0, O, "late_new_after");
    cyc(1, P, "abort_press");
    cyc(0, R, "abort_release");
    cyc(0, B, "abort_gap1");
    cyc(0, B, "abort_gap2");
    rst = 1'b0;
    #1;
    check("abort_async_reset", O);
    @(negedge clk);
    check("abort_in_reset", O);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cyc(0, O, "abort_after");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
